hitbox_probe_ctrl: RTL

//  Sequences the level map's single collision lookup port (x2/y2 -> data2) to test a hitbox against the tile map.

---
 rtl/hitbox_probe_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hitbox_probe_ctrl.sv
// Hitbox-vs-tilemap collision sequencer: owns the level map's collision lookup port
// and walks eight edge probes per request to build an {up,down,left,right} contact mask.
module hitbox_probe_ctrl #(
    parameter int HB_W = 32,
    parameter int HB_H = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] req_x,
    input  logic [9:0] req_y,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    input  logic       probe_hit,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_mask,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [9:0] ONE    = 10'd1;
    localparam logic [9:0] W_FULL = 10'(HB_W);
    localparam logic [9:0] W_M1   = 10'(HB_W - 1);
    localparam logic [9:0] H_FULL = 10'(HB_H);
    localparam logic [9:0] H_M1   = 10'(HB_H - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] idx_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic [3:0] acc_q;
    logic [9:0] probe_x_q;
    logic [9:0] probe_y_q;
    logic       accept;

    // Probe point i for hitbox top-left (x,y); all arithmetic wraps at 10 bits.
    function automatic logic [19:0] probe_point(input logic [9:0] x,
                                                input logic [9:0] y,
                                                input logic [2:0] i);
        logic [9:0] px;
        logic [9:0] py;
        case (i)
            3'd0:    begin px = x;        py = y - ONE;  end
            3'd1:    begin px = x + W_M1; py = y - ONE;  end
            3'd2:    begin px = x;        py = y + H_FULL; end
            3'd3:    begin px = x + W_M1; py = y + H_FULL; end
            3'd4:    begin px = x - ONE;  py = y;        end
            3'd5:    begin px = x - ONE;  py = y + H_M1; end
            3'd6:    begin px = x + W_FULL; py = y;      end
            default: begin px = x + W_FULL; py = y + H_M1; end
        endcase
        return {px, py};
    endfunction

    // Probes come in pairs per side: 0-1 up, 2-3 down, 4-5 left, 6-7 right.
    function automatic logic [3:0] side_bit(input logic [2:0] i);
        return 4'b1000 >> i[2:1];
    endfunction

    assign accept = req_valid && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = PROBE;
            PROBE:   if (idx_q == 3'd7) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Probe address is registered so the level port sees a glitch-free point for a full cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 3'd0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            acc_q     <= 4'd0;
            probe_x_q <= 10'd0;
            probe_y_q <= 10'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q                    <= req_x;
                        y_q                    <= req_y;
                        acc_q                  <= 4'd0;
                        idx_q                  <= 3'd0;
                        {probe_x_q, probe_y_q} <= probe_point(req_x, req_y, 3'd0);
                    end
                end
                PROBE: begin
                    if (probe_hit) begin
                        acc_q <= acc_q | side_bit(idx_q);
                    end
                    idx_q <= idx_q + 3'd1;
                    if (idx_q != 3'd7) begin
                        {probe_x_q, probe_y_q} <= probe_point(x_q, y_q, idx_q + 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q == PROBE) || (state_q == DONE);
        res_valid = (state_q == DONE);
        res_mask  = (state_q == DONE) ? acc_q : 4'd0;
        probe_x   = probe_x_q;
        probe_y   = probe_y_q;
    end

endmodule
